// File: rtl/local_store_responder_if.sv
// rtl/local_store_responder_if.sv - odd-pipe local store request/response bundle
interface local_store_responder_if;
   logic         req_valid;
   logic         req_ready;
   logic         req_wrt_en;
   logic [0:14]  req_address;
   logic [0:127] req_data;
   logic         rsp_valid;
   logic [0:127] rsp_data;
   logic         init_done;

   modport master (
      output req_valid, req_wrt_en, req_address, req_data,
      input  req_ready, rsp_valid, rsp_data, init_done
   );

   modport slave (
      input  req_valid, req_wrt_en, req_address, req_data,
      output req_ready, rsp_valid, rsp_data, init_done
   );
endinterface

// File: rtl/local_store_responder.sv
// rtl/local_store_responder.sv - local store array with zero-fill sweep and fixed-latency loads
module local_store_responder #(
   parameter int DEPTH        = 2048,
   parameter int READ_LATENCY = 3,
   parameter bit INIT_ZERO    = 1'b1
) (
   input logic clock,
   input logic reset,
   local_store_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {INIT, READY} state_t;

   state_t                  state;
   logic [AW-1:0]           init_cnt;
   logic                    ready_q;
   logic                    done_q;
   logic [0:127]            mem [DEPTH];
   logic [AW-1:0]           idx;
   logic                    store_accept;
   logic                    load_accept;
   logic                    mem_we;
   logic [AW-1:0]           mem_idx;
   logic [0:127]            mem_wdata;
   logic [READ_LATENCY-1:0] pipe_valid;
   logic [0:127]            pipe_data [READ_LATENCY];
   logic                    unused_addr;

   // Quadword index is the upper address bits; the byte offset is ignored.
   assign idx          = bus.req_address[0:AW-1];
   assign unused_addr  = ^bus.req_address[AW:14];
   assign store_accept = bus.req_valid & ready_q & bus.req_wrt_en;
   assign load_accept  = bus.req_valid & ready_q & ~bus.req_wrt_en;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= INIT_ZERO ? INIT : READY;
         init_cnt <= '0;
         ready_q  <= !INIT_ZERO;
         done_q   <= !INIT_ZERO;
      end else begin
         case (state)
            INIT: begin
               init_cnt <= init_cnt + AW'(1);
               if (init_cnt == AW'(DEPTH - 1)) begin
                  state   <= READY;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            READY: begin
               ready_q <= 1'b1;
               done_q  <= 1'b1;
            end
            default: state <= INIT;
         endcase
      end
   end

   // The sweep owns the write port until READY; reset itself never writes.
   always_comb begin
      mem_we    = 1'b0;
      mem_idx   = idx;
      mem_wdata = bus.req_data;
      if (state == INIT && !reset) begin
         mem_we    = 1'b1;
         mem_idx   = init_cnt;
         mem_wdata = '0;
      end else if (store_accept) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we)
         mem[mem_idx] <= mem_wdata;
   end

   // Each stage only advances valid data so the output holds its last load.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pipe_valid <= '0;
         for (int i = 0; i < READ_LATENCY; i++)
            pipe_data[i] <= '0;
      end else begin
         pipe_valid[0] <= load_accept;
         if (load_accept)
            pipe_data[0] <= mem[idx];
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            if (pipe_valid[i-1])
               pipe_data[i] <= pipe_data[i-1];
         end
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.init_done = done_q;
   assign bus.rsp_valid = pipe_valid[READ_LATENCY-1];
   assign bus.rsp_data  = pipe_data[READ_LATENCY-1];
endmodule

// File: tb/tb_local_store_responder.sv
// tb/tb_local_store_responder.sv - randomized bench for local_store_responder against an array/queue model
module tb_local_store_responder;
   logic clock = 1'b0;
   logic reset = 1'b1;

   local_store_responder_if bus ();

   local_store_responder dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int           due;
      logic [127:0] data;
   } rsp_t;

   logic [127:0] ref_mem [2048];
   rsp_t         exp_q [$];
   int           edge_n = 0;
   int           errors = 0;
   int           checks = 0;
   int           ridx;

   task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, edge_n);
      end
   endtask

   // Reference: ready after 2048 edges out of reset; loads answer two edges after the accepting one.
   always @(posedge clock) begin
      if (!reset) begin
         edge_n++;
         if (edge_n > 2048 && bus.req_valid) begin
            ridx = int'(bus.req_address[0:10]);
            if (bus.req_wrt_en)
               ref_mem[ridx] = bus.req_data;
            else
               exp_q.push_back('{edge_n + 2, ref_mem[ridx]});
         end
      end
   end

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic drive(bit v, bit w, logic [0:14] a, logic [127:0] d);
      bus.req_valid   = v;
      bus.req_wrt_en  = w;
      bus.req_address = a;
      bus.req_data    = d;
   endtask

   task automatic tick();
      @(negedge clock);
      check("req_ready", 128'(bus.req_ready), 128'(edge_n >= 2048));
      check("init_done", 128'(bus.init_done), 128'(edge_n >= 2048));
      if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
         check("rsp_valid", 128'(bus.rsp_valid), 128'(1));
         check("rsp_data", bus.rsp_data, exp_q[0].data);
         void'(exp_q.pop_front());
      end else begin
         check("rsp_idle", 128'(bus.rsp_valid), 128'(0));
      end
   endtask

   task automatic do_reset(int hold);
      reset  = 1'b1;
      edge_n = 0;
      exp_q.delete();
      foreach (ref_mem[i]) ref_mem[i] = '0;
      drive(1'b0, 1'b0, 15'h0, '0);
      #1;
      check("rst_ready", 128'(bus.req_ready), 128'(0));
      check("rst_done", 128'(bus.init_done), 128'(0));
      check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      check("rst_rsp_data", bus.rsp_data, 128'(0));
      repeat (hold) tick();
      reset = 1'b0;
   endtask

   task automatic run_sweep(bit junk);
      while (edge_n < 2048) begin
         if (junk)
            drive(1'b1, 1'b1, 15'($urandom()), rnd128());
         else
            drive(1'b0, 1'b0, 15'h0, '0);
         tick();
      end
      drive(1'b0, 1'b0, 15'h0, '0);
   endtask

   task automatic op(bit w, logic [0:14] a, logic [127:0] d);
      drive(1'b1, w, a, d);
      tick();
      drive(1'b0, 1'b0, 15'h0, '0);
   endtask

   initial begin
      logic [10:0] ri;
      logic [3:0]  rl;

      do_reset(3);
      repeat (1000) tick();
      do_reset(2);
      run_sweep(1'b1);

      op(1'b0, 15'h0000, '0);
      op(1'b0, 15'h7FF0, '0);
      repeat (4) tick();

      op(1'b1, 15'h0060, 128'd15);
      op(1'b0, 15'h0060, '0);
      repeat (4) tick();
      op(1'b1, 15'h006B, 128'd13);
      op(1'b0, 15'h0060, '0);
      repeat (4) tick();

      op(1'b1, 15'h0010, 128'hA);
      op(1'b1, 15'h0020, 128'hB);
      op(1'b1, 15'h0030, 128'hC);
      drive(1'b1, 1'b0, 15'h0010, '0); tick();
      drive(1'b1, 1'b0, 15'h0020, '0); tick();
      drive(1'b1, 1'b0, 15'h0030, '0); tick();
      drive(1'b0, 1'b0, 15'h0, '0);
      repeat (4) tick();

      for (int n = 0; n < 3000; n++) begin
         ri = 11'(($urandom_range(0, 15) * 97) % 2048);
         rl = 4'($urandom());
         drive($urandom_range(0, 9) < 7, 1'($urandom()), {ri, rl}, rnd128());
         tick();
      end
      drive(1'b0, 1'b0, 15'h0, '0);
      repeat (5) tick();
      check("drain", 128'(exp_q.size()), 128'(0));

      op(1'b1, 15'h0060, 128'h1234_5678);
      op(1'b0, 15'h0060, '0);
      do_reset(3);
      run_sweep(1'b0);
      op(1'b0, 15'h0060, '0);
      op(1'b0, 15'h0010, '0);
      repeat (5) tick();
      check("final_drain", 128'(exp_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
